// File: rtl/register_feed_fifo_pkg.sv
// register_feed_fifo_pkg: constants shared between the feed FIFO and the 16-bit Register it drives
package register_feed_fifo_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_ADDR_BITS = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/register_feed_fifo_if.sv
// register_feed_fifo_if: producer-side and consumer-side handshake bundle of the feed FIFO
interface register_feed_fifo_if
  import register_feed_fifo_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int ADDR_BITS = FIFO_ADDR_BITS
);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [ADDR_BITS:0] count;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, count);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, count);
endinterface

// File: rtl/register_feed_fifo_wrap_counter.sv
// register_feed_fifo_wrap_counter: pointer that increments on enable and wraps modulo 2**BITS
module register_feed_fifo_wrap_counter #(
  parameter int BITS = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en_i,
  output logic [BITS-1:0] q_o
);
  logic [BITS-1:0] cnt_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign q_o = cnt_q;
endmodule

// File: rtl/register_feed_fifo.sv
// register_feed_fifo: first-word fall-through FIFO whose pop strobe enables the downstream Register
module register_feed_fifo
  import register_feed_fifo_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input logic clock,
  input logic reset,
  register_feed_fifo_if.slave bus
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_BITS:0] count_q, count_d;
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic push, pop, full, empty;
  assign full = count_q == (ADDR_BITS+1)'(DEPTH);
  assign empty = count_q == '0;
  assign push = bus.in_valid && !full;
  assign pop = bus.out_ready && !empty;
  always_comb count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  // storage is left uncleared by reset; out_data masks it while empty
  always_ff @(posedge clock)
    if (push) mem_q[wr_ptr] <= bus.in_data;
  register_feed_fifo_wrap_counter #(.BITS(ADDR_BITS)) u_wr (.clock(clock), .reset(reset), .en_i(push), .q_o(wr_ptr));
  register_feed_fifo_wrap_counter #(.BITS(ADDR_BITS)) u_rd (.clock(clock), .reset(reset), .en_i(pop), .q_o(rd_ptr));
  assign bus.in_ready = !full;
  assign bus.out_valid = !empty;
  assign bus.count = count_q;
  assign bus.out_data = empty ? '0 : mem_q[rd_ptr];
endmodule

// File: tb/tb_register_feed_fifo.sv
// tb_register_feed_fifo: queue-model checked bench for the feed FIFO chained into a 16-bit Register
module tb_register_feed_fifo;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_err = 0;
  register_feed_fifo_if #(.WIDTH(16), .ADDR_BITS(2)) bus ();
  register_feed_fifo dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] q [$];
  logic [15:0] model_reg;
  logic [15:0] dut_reg;
  // the Register downstream: captures out_data whenever the FIFO pops
  always_ff @(posedge clk or posedge rst)
    if (rst) dut_reg <= '0;
    else if (bus.out_valid && bus.out_ready) dut_reg <= bus.out_data;
  initial begin
    model_reg = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        model_reg = 0;
      end else begin
        automatic bit do_pop = bus.out_ready && q.size() > 0;
        automatic bit do_push = bus.in_valid && q.size() < 4;
        automatic logic [15:0] d = bus.in_data;
        if (do_pop) begin
          model_reg = q[0];
          void'(q.pop_front());
        end
        if (do_push) q.push_back(d);
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    check("model.count", 32'(bus.count), 32'(q.size()));
    check("model.in_ready", 32'(bus.in_ready), 32'(q.size() < 4));
    check("model.out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    check("model.out_data", 32'(bus.out_data), q.size() > 0 ? 32'(q[0]) : 32'd0);
    check("model.register", 32'(dut_reg), 32'(model_reg));
  end
  task automatic cyc(input bit iv, input logic [15:0] d, input bit ordy);
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = ordy;
    @(negedge clk);
  endtask
  initial begin
    logic [15:0] exp3 [4];
    logic [15:0] got;
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      check("idle.out_valid", 32'(bus.out_valid), 0);
      check("idle.in_ready", 32'(bus.in_ready), 1);
      check("idle.count", 32'(bus.count), 0);
      check("idle.out_data", 32'(bus.out_data), 0);
    end
    cyc(1, 31, 0);
    check("one.out_valid", 32'(bus.out_valid), 1);
    check("one.out_data", 32'(bus.out_data), 31);
    check("one.count", 32'(bus.count), 1);
    cyc(0, 0, 1);
    check("one.pop_count", 32'(bus.count), 0);
    check("one.pop_valid", 32'(bus.out_valid), 0);
    exp3 = '{16'd31, 16'd127, 16'd1023, 16'd7};
    for (int i = 0; i < 4; i++) cyc(1, exp3[i], 0);
    check("full.count", 32'(bus.count), 4);
    check("full.in_ready", 32'(bus.in_ready), 0);
    cyc(1, 9, 0);
    check("full.reject_count", 32'(bus.count), 4);
    for (int i = 0; i < 4; i++) begin
      check("drain.order", 32'(bus.out_data), 32'(exp3[i]));
      cyc(0, 0, 1);
    end
    check("drain.count", 32'(bus.count), 0);
    for (int i = 0; i < 3; i++) cyc(1, 16'(200 + i), 0);
    for (int i = 0; i < 6; i++) begin
      got = bus.out_data;
      check("stream.order", 32'(got), i < 3 ? 32'(200 + i) : 32'(97 + i));
      cyc(1, 16'(100 + i), 1);
      check("stream.count", 32'(bus.count), 3);
    end
    for (int i = 0; i < 3; i++) begin
      check("stream.tail", 32'(bus.out_data), 32'(103 + i));
      cyc(0, 0, 1);
    end
    for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 0);
    cyc(1, 99, 1);
    check("fullpop.count", 32'(bus.count), 3);
    check("fullpop.in_ready", 32'(bus.in_ready), 1);
    for (int i = 2; i <= 4; i++) begin
      check("fullpop.order", 32'(bus.out_data), 32'(i));
      cyc(0, 0, 1);
    end
    check("fullpop.empty", 32'(bus.out_valid), 0);
    cyc(1, 10, 0);
    cyc(1, 11, 0);
    check("areset.pre_count", 32'(bus.count), 2);
    bus.in_valid = 0;
    #2 rst = 1;
    #1;
    check("areset.out_valid", 32'(bus.out_valid), 0);
    check("areset.count", 32'(bus.count), 0);
    check("areset.in_ready", 32'(bus.in_ready), 1);
    check("areset.out_data", 32'(bus.out_data), 0);
    rst = 0;
    cyc(1, 55, 0);
    check("areset.first_push", 32'(bus.out_data), 55);
    check("areset.first_count", 32'(bus.count), 1);
    cyc(0, 0, 1);
    cyc(1, 31, 0);
    cyc(1, 127, 1);
    check("chain.first", 32'(dut_reg), 31);
    cyc(0, 0, 1);
    check("chain.second", 32'(dut_reg), 127);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("chain.hold", 32'(dut_reg), 127);
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 200; i++)
      cyc(($urandom_range(0, 1) != 0), 16'($urandom), ($urandom_range(0, 3) == 0));
    cyc(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
